// File: rtl/conv_window_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_gen_if
// Description : Bundle of the FIFO-side and window-side signals of
//               conv_window_gen.
//               master : the window generator (pops the FIFO, drives windows)
//               slave  : the environment (FIFO head plus MAC-array ready)
// Signals     : fifo_empty, fifo_q, fifo_rdreq   show-ahead FIFO read port
//               win_valid, win_ready, win_data   3x3 window handshake
//               col, row                         position of next pixel
//               frame_done                       end-of-frame pulse
// Revision    : 1.0  initial release
// ============================================================================
interface conv_window_gen_if #(
  parameter int WIDTH = 16,
  parameter int CW    = 5,
  parameter int RW    = 5
);
  logic               fifo_empty;
  logic [WIDTH-1:0]   fifo_q;
  logic               fifo_rdreq;
  logic               win_valid;
  logic               win_ready;
  logic [9*WIDTH-1:0] win_data;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic               frame_done;

  modport master (
    input  fifo_empty, fifo_q, win_ready,
    output fifo_rdreq, win_valid, win_data, col, row, frame_done
  );

  modport slave (
    output fifo_empty, fifo_q, win_ready,
    input  fifo_rdreq, win_valid, win_data, col, row, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_gen
// Description : Builds 3x3 valid-mode convolution windows over an
//               IMG_W x IMG_H pixel stream read from a show-ahead FIFO.
//               Two IMG_W-deep line buffers hold the previous two rows;
//               each accepted pixel shifts a new column into the window.
// Ports       : clock         rising-edge clock
//               clock_sreset  synchronous active-high reset
//               bus (master)  FIFO read port, window valid/ready output,
//                             col/row position, frame_done pulse
// Revision    : 1.0  initial release
// ============================================================================
module conv_window_gen #(
  parameter int WIDTH = 16,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int CW    = $clog2(IMG_W),
  parameter int RW    = $clog2(IMG_H)
) (
  input  logic                 clock,
  input  logic                 clock_sreset,
  conv_window_gen_if.master    bus
);

  logic               accept;
  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  logic               win_valid_q, win_valid_d;
  logic [9*WIDTH-1:0] win_data_q, win_data_d;
  logic               frame_done_q, frame_done_d;
  logic [9*WIDTH-1:0] win_shift;
  logic [WIDTH-1:0]   new_col [3];
  logic               last_col, last_row;

  // Line buffers: lb0 holds the previous row, lb1 the row before that.
  logic [WIDTH-1:0] lb0_mem [IMG_W];
  logic [WIDTH-1:0] lb1_mem [IMG_W];
  logic [WIDTH-1:0] lb0_rd, lb1_rd;

  // A pop is only legal when the FIFO has data and the output slot is free
  // or being drained this very cycle.
  assign accept = ~bus.fifo_empty & ~clock_sreset & (~win_valid_q | bus.win_ready);

  assign lb0_rd = lb0_mem[col_q];
  assign lb1_rd = lb1_mem[col_q];

  // Read-before-write at the same address: the old lb0 entry moves to lb1.
  // Contents are intentionally not reset; row masking hides stale data.
  always_ff @(posedge clock) begin
    if (accept) begin
      lb1_mem[col_q] <= lb0_rd;
      lb0_mem[col_q] <= bus.fifo_q;
    end
  end

  // Incoming column, oldest row first.
  assign new_col[0] = lb1_rd;
  assign new_col[1] = lb0_rd;
  assign new_col[2] = bus.fifo_q;

  // Each window row shifts one column left and takes the new pixel at c=2.
  generate
    for (genvar r = 0; r < 3; r++) begin : g_row
      assign win_shift[WIDTH*(3*r+0) +: WIDTH] = win_data_q[WIDTH*(3*r+1) +: WIDTH];
      assign win_shift[WIDTH*(3*r+1) +: WIDTH] = win_data_q[WIDTH*(3*r+2) +: WIDTH];
      assign win_shift[WIDTH*(3*r+2) +: WIDTH] = new_col[r];
    end
  endgenerate

  assign last_col = (col_q == CW'(IMG_W - 1));
  assign last_row = (row_q == RW'(IMG_H - 1));

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_valid_d  = win_valid_q;
    win_data_d   = win_data_q;
    frame_done_d = 1'b0;
    if (accept) begin
      frame_done_d = last_col & last_row;
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      // The window register doubles as the shift register, so it advances
      // on every accept; only positions with two rows and two columns of
      // history are flagged valid, which also keeps windows off row edges.
      win_data_d  = win_shift;
      win_valid_d = (row_q >= RW'(2)) & (col_q >= CW'(2));
    end else if (bus.win_ready) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      win_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      win_data_q   <= win_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.fifo_rdreq = accept;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_data   = win_data_q;
  assign bus.col        = col_q;
  assign bus.row        = row_q;
  assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_window_gen
// Description : Self-checking bench for conv_window_gen. A 4x4 instance and
//               a 5x3 instance are fed from a queue-modelled show-ahead FIFO;
//               emitted windows are compared with a table of hand-computed
//               windows.
// Revision    : 1.0  initial release
// ============================================================================
module tb_conv_window_gen;

  localparam int WD = 16;

  logic clock = 1'b0;
  logic clock_sreset;
  always #5 clock = ~clock;

  conv_window_gen_if #(.WIDTH(WD), .CW(2), .RW(2)) b4 ();
  conv_window_gen_if #(.WIDTH(WD), .CW(3), .RW(2)) b5 ();

  conv_window_gen #(.WIDTH(WD), .IMG_W(4), .IMG_H(4)) u_dut4 (
    .clock(clock), .clock_sreset(clock_sreset), .bus(b4.master));
  conv_window_gen #(.WIDTH(WD), .IMG_W(5), .IMG_H(3)) u_dut5 (
    .clock(clock), .clock_sreset(clock_sreset), .bus(b5.master));

  typedef struct {
    int sel;    // 0: 4x4 instance, 1: 5x3 instance
    int idx;    // window index within the frame
    int e[9];   // expected elements, relative to the frame's first pixel
  } vec_t;

  vec_t tbl[7];

  int tests = 0;
  int fails = 0;

  logic [WD-1:0]   pq[$];
  logic [9*WD-1:0] got[$];
  int cyc, fd_n, fd_cyc, last_pop, bad_rd, stall_left, held_n, held_bad;
  logic [9*WD-1:0] held_d;

  task automatic chk(input string name, input logic [9*WD-1:0] act, input logic [9*WD-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [9*WD-1:0] pack_win(input int i, input int base);
    logic [9*WD-1:0] p;
    p = '0;
    for (int k = 0; k < 9; k++) p[WD*k +: WD] = WD'(tbl[i].e[k] + base);
    return p;
  endfunction

  task automatic drive(input int sel, input bit emp, input logic [WD-1:0] q, input bit rdy);
    if (sel == 0) begin
      b4.fifo_empty = emp; b4.fifo_q = q;  b4.win_ready = rdy;
      b5.fifo_empty = 1'b1; b5.fifo_q = '0; b5.win_ready = 1'b0;
    end else begin
      b5.fifo_empty = emp; b5.fifo_q = q;  b5.win_ready = rdy;
      b4.fifo_empty = 1'b1; b4.fifo_q = '0; b4.win_ready = 1'b0;
    end
  endtask

  // One clock cycle: inputs change on the falling edge, outputs are sampled
  // 1 time unit later, and the FIFO model pops when rdreq was seen high.
  task automatic step(input int sel, input bit allow, input bit ready_req);
    bit emp, rd, v, fd, rdy;
    logic [WD-1:0] q;
    logic [9*WD-1:0] d;
    @(negedge clock);
    emp = !allow || (pq.size() == 0);
    q = '0;
    if (!emp) q = pq[0];
    v = (sel != 0) ? b5.win_valid : b4.win_valid;
    rdy = ready_req;
    if (v && stall_left > 0) begin
      rdy = 1'b0;
      stall_left--;
    end
    drive(sel, emp, q, rdy);
    #1;
    rd = (sel != 0) ? b5.fifo_rdreq : b4.fifo_rdreq;
    d  = (sel != 0) ? b5.win_data   : b4.win_data;
    fd = (sel != 0) ? b5.frame_done : b4.frame_done;
    cyc++;
    if (rd && emp) bad_rd++;
    if (v && !rdy) begin
      if (held_n == 0) held_d = d;
      else if (d !== held_d) held_bad++;
      if (rd) held_bad++;
      held_n++;
    end
    if (v && rdy) got.push_back(d);
    if (fd) begin
      fd_n++;
      fd_cyc = cyc;
    end
    if (rd) begin
      last_pop = cyc;
      void'(pq.pop_front());
    end
  endtask

  task automatic run(input int sel, input bit bubble, input int n);
    for (int i = 0; i < n; i++) step(sel, bubble ? (i % 2 == 0) : 1'b1, 1'b1);
  endtask

  task automatic clr();
    got.delete();
    fd_n = 0; fd_cyc = -100; last_pop = -100; bad_rd = 0;
    held_n = 0; held_bad = 0; stall_left = 0;
  endtask

  task automatic push_frame(input int base, input int n);
    for (int i = 0; i < n; i++) pq.push_back(WD'(base + i));
  endtask

  task automatic chk_windows(input string name, input int sel, input int off, input int base);
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].sel == sel) begin
        if (off + tbl[i].idx < got.size()) begin
          chk($sformatf("%s%0d", name, tbl[i].idx), got[off + tbl[i].idx], pack_win(i, base));
        end else begin
          tests++;
          fails++;
          $display("FAIL %s%0d: window missing, got %0d windows", name, tbl[i].idx, got.size());
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lows;
    tbl[0] = '{0, 0, '{0, 1, 2, 4, 5, 6, 8, 9, 10}};
    tbl[1] = '{0, 1, '{1, 2, 3, 5, 6, 7, 9, 10, 11}};
    tbl[2] = '{0, 2, '{4, 5, 6, 8, 9, 10, 12, 13, 14}};
    tbl[3] = '{0, 3, '{5, 6, 7, 9, 10, 11, 13, 14, 15}};
    tbl[4] = '{1, 0, '{0, 1, 2, 5, 6, 7, 10, 11, 12}};
    tbl[5] = '{1, 1, '{1, 2, 3, 6, 7, 8, 11, 12, 13}};
    tbl[6] = '{1, 2, '{2, 3, 4, 7, 8, 9, 12, 13, 14}};

    cyc = 0;
    clr();
    clock_sreset = 1'b1;
    drive(0, 1'b1, '0, 1'b0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    chk_i("rst_valid", int'(b4.win_valid), 0);
    chk_i("rst_frame_done", int'(b4.frame_done), 0);
    chk_i("rst_row", int'(b4.row), 0);
    chk_i("rst_col", int'(b4.col), 0);
    chk("rst_data", b4.win_data, '0);
    chk_i("rst_rdreq", int'(b4.fifo_rdreq), 0);
    clock_sreset = 1'b0;

    // Plain 4x4 frame, always ready
    clr();
    push_frame(0, 16);
    run(0, 1'b0, 30);
    chk_i("s1_count", got.size(), 4);
    chk_windows("s1_win", 0, 0, 0);
    chk_i("s1_fd_count", fd_n, 1);
    chk_i("s1_fd_latency", fd_cyc - last_pop, 1);
    chk_i("s1_bad_rdreq", bad_rd, 0);

    // Backpressure on window0 for five cycles
    clr();
    stall_left = 5;
    push_frame(0, 16);
    run(0, 1'b0, 35);
    chk_i("s2_stall_cycles", held_n, 5);
    chk_i("s2_stall_violations", held_bad, 0);
    chk_i("s2_count", got.size(), 4);
    chk_windows("s2_win", 0, 0, 0);

    // FIFO bubbles every other cycle
    clr();
    push_frame(0, 16);
    run(0, 1'b1, 50);
    chk_i("s3_count", got.size(), 4);
    chk_windows("s3_win", 0, 0, 0);
    chk_i("s3_bad_rdreq", bad_rd, 0);
    chk_i("s3_fd_count", fd_n, 1);

    // Two back-to-back frames
    clr();
    push_frame(0, 16);
    push_frame(100, 16);
    run(0, 1'b0, 50);
    chk_i("s4_count", got.size(), 8);
    chk_windows("s4_f0_win", 0, 0, 0);
    chk_windows("s4_f1_win", 0, 4, 100);
    lows = 0;
    for (int w = 4; w < got.size(); w++)
      for (int k = 0; k < 9; k++)
        if (got[w][WD*k +: WD] < WD'(100)) lows++;
    chk_i("s4_f1_low_values", lows, 0);
    chk_i("s4_fd_count", fd_n, 2);

    // Reset in the middle of a frame, after pixel 9
    clr();
    push_frame(0, 10);
    run(0, 1'b0, 14);
    chk_i("s5_pre_row", int'(b4.row), 2);
    chk_i("s5_pre_col", int'(b4.col), 2);
    chk_i("s5_pre_count", got.size(), 0);
    clock_sreset = 1'b1;
    @(negedge clock);
    #1;
    chk_i("s5_rst_valid", int'(b4.win_valid), 0);
    chk_i("s5_rst_row", int'(b4.row), 0);
    chk_i("s5_rst_col", int'(b4.col), 0);
    clock_sreset = 1'b0;
    clr();
    push_frame(0, 16);
    run(0, 1'b0, 30);
    chk_i("s5_count", got.size(), 4);
    chk_windows("s5_win", 0, 0, 0);

    // 5x3 instance
    clr();
    push_frame(0, 15);
    run(1, 1'b0, 30);
    chk_i("s6_count", got.size(), 3);
    chk_windows("s6_win", 1, 0, 0);
    chk_i("s6_fd_count", fd_n, 1);
    chk_i("s6_fd_latency", fd_cyc - last_pop, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Consumes the pixel stream held in the upstream synchronous FIFO.
- Uses the FIFO's show-ahead `q`/`empty` interface and pops with `rdreq`.
- Builds 3x3 convolution windows over an IMG_W x IMG_H frame, using valid (no-padding) semantics.
- Presents each window on a registered valid/ready output to the MAC array.
- Two internal line buffers hold the previous two image rows.

Parameters:
- WIDTH, 16, pixel width in bits.
- IMG_W, 32, pixels per row; legal range 3..4096.
- IMG_H, 32, rows per frame; legal range 3..4096.
- CW, $clog2(IMG_W), column counter width.
- RW, $clog2(IMG_H), row counter width.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- clock_sreset  in  1  synchronous, active-high reset.
- fifo_empty  in  1  upstream FIFO empty.
- fifo_q  in  WIDTH  upstream FIFO head word; valid in the same cycle whenever fifo_empty=0.
- fifo_rdreq  out  1  pop strobe to upstream FIFO.
- win_valid  out  1  window valid.
- win_ready  in  1  downstream accepts the window this cycle.
- win_data  out  9*WIDTH  window; element (r,c) at [WIDTH*(3*r+c) +: WIDTH]. r=0 is the oldest row, c=0 the oldest column.
- col  out  CW  column index of the next pixel to be accepted.
- row  out  RW  row index of the next pixel to be accepted.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (clock_sreset=1 at a clock edge): win_valid=0, frame_done=0, col=0, row=0, win_data=0, shift window cleared.
  - fifo_rdreq is combinational and therefore 0 while win_valid=0 and fifo_empty=1.
  - Line-buffer RAM contents are not reset; row masking makes stale data harmless.
- Reset mid-frame: the partial frame is abandoned and the next popped pixel is (0,0).
- Pop rule: fifo_rdreq = ~fifo_empty & ~clock_sreset & (~win_valid | win_ready).
  - Never asserted while fifo_empty=1, so the upstream FIFO never flags an illegal read.
  - A pop is an "accept"; fifo_q is sampled in the accept cycle.
- On accept:
  - lb1[col] <= lb0[col]; lb0[col] <= fifo_q. The two line buffers are IMG_W deep, read-before-write at the same address.
  - Window columns shift left: column 2 becomes {lb1[col], lb0[col], fifo_q}, rows 0..2 respectively.
  - col increments; at IMG_W-1 it wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0 and frame_done=1 in the next cycle only.
- Window emit: win_valid is set in the cycle after an accept whose pixel had row>=2 and col>=2.
  - win_data is registered with the shifted window (latency 1 from pop).
- Handshake:
  - win_valid & win_ready in the same cycle consumes the window.
  - If an accept occurs in that same cycle, win_valid reloads per the emit rule; otherwise it clears.
  - While win_valid & ~win_ready: no pop, and win_data/win_valid are held stable.
- Accepts whose pixel has row<2 or col<2 update the state but produce no window. Windows never straddle a row boundary because col<2 is masked.
- Frame boundary:
  - Frames stream back-to-back with no bubble required.
  - Rows 0..1 of a new frame mask out windows, so pixels from the previous frame never appear in an emitted window.
- Windows per frame = (IMG_W-2)*(IMG_H-2), emitted in raster order.
- FIFO bubbles (fifo_empty=1) stall the state; no window is lost or duplicated.

Test Plan:
- IMG_W=4, IMG_H=4, pixels 0..15 pushed, win_ready=1:
  - exactly 4 windows are emitted;
  - window0 = {0,1,2,4,5,6,8,9,10}, window1 = {1,2,3,5,6,7,9,10,11}, window2 = {4,5,6,8,9,10,12,13,14}, window3 = {5,6,7,9,10,11,13,14,15};
  - frame_done pulses once, 1 cycle after pixel 15 is popped.
- Backpressure: hold win_ready=0 for 5 cycles while window0 is valid -> fifo_rdreq=0 for those cycles, win_data stays constant, and the following windows are identical to the previous scenario.
- FIFO bubbles: feed 16 pixels with fifo_empty toggling every other cycle -> the same 4 windows, and fifo_rdreq is never high while fifo_empty=1.
- Two back-to-back frames (pixels 0..15, then 100..115) -> second-frame window0 = {100,101,102,104,105,106,108,109,110}, with no value below 100 in any of its windows.
- Reset asserted after pixel 9 of a frame -> next cycle win_valid=0, row=0, col=0. A fresh 16-pixel frame then produces exactly 4 correct windows.
- IMG_W=5, IMG_H=3, pixels 0..14 -> 3 windows: {0,1,2,5,6,7,10,11,12}, {1,2,3,6,7,8,11,12,13}, {2,3,4,7,8,9,12,13,14}.
